// File: rtl/seq_gen_1011.sv
// Serial 1011 pattern transmitter: shifts a loaded word out MSB-first with a zero gap
// between frames, and tracks its own output for expected 1011 matches.
module seq_gen_1011 #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH-1:0]           load_data,
    input  logic [$clog2(WIDTH+1)-1:0] load_len,
    output logic                       out,
    output logic                       out_valid,
    output logic                       done,
    output logic                       match_exp,
    output logic [CNT_W-1:0]           match_cnt,
    input  logic                       cnt_clr
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [IW-1:0]    idx;
    logic [GW-1:0]    gap_cnt;
    logic [3:0]       hist;
    logic [LW-1:0]    len_c;
    logic [IW-1:0]    first_idx;
    logic             accept;

    always_comb begin
        len_c     = (load_len > LW'(WIDTH)) ? LW'(WIDTH) : load_len;
        first_idx = IW'(len_c - LW'(1));
        accept    = (state == ST_IDLE) && load_valid && load_ready;
    end

    // hist[0] is the most recent out value; oldest bit sits in hist[3]
    assign match_exp = (hist == 4'b1011);

    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            load_ready <= 1'b0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            idx        <= '0;
            gap_cnt    <= '0;
            hist       <= 4'b0000;
        end else begin
            hist <= {hist[2:0], out};
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    load_ready <= 1'b1;
                    out        <= 1'b0;
                    out_valid  <= 1'b0;
                    if (accept) begin
                        if (len_c == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= ST_SHIFT;
                            load_ready <= 1'b0;
                            idx        <= first_idx;
                            out        <= load_data[first_idx];
                            out_valid  <= 1'b1;
                            done       <= (first_idx == '0);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (idx == '0) begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        if (GAP > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= GW'(GAP - 1);
                        end else begin
                            state      <= ST_IDLE;
                            load_ready <= 1'b1;
                        end
                    end else begin
                        idx  <= idx - 1'b1;
                        out  <= data_q[idx - 1'b1];
                        done <= (idx == IW'(1));
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state      <= ST_IDLE;
                        load_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (match_exp && (match_cnt != '1)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_gen_1011.sv
// Scoreboard bench for seq_gen_1011: three instances (GAP=2, GAP=0, CNT_W=2) driven by
// directed frames; a monitor pops expected bits whenever a DUT presents one.
`timescale 1ns/1ps
module tb_seq_gen_1011;

    typedef struct packed {
        logic b;
        logic d;
        logic z;
        logic m;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      lv, lr, o, ov, dn, mx, clr;
    logic [2:0][7:0] ld, mc;
    logic [2:0][3:0] ll;

    int   vectors     = 0;
    int   miscompares = 0;
    ent_t q[3][$];
    logic pend_m[3];
    logic armed[3];
    int   since[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int GP = (g == 1) ? 0 : 2;
        localparam int CW = (g == 2) ? 2 : 8;
        logic [CW-1:0] mcw;
        seq_gen_1011 #(.WIDTH(8), .GAP(GP), .CNT_W(CW)) dut (
            .clk       (clk),
            .reset     (rst_n),
            .load_valid(lv[g]),
            .load_ready(lr[g]),
            .load_data (ld[g]),
            .load_len  (ll[g]),
            .out       (o[g]),
            .out_valid (ov[g]),
            .done      (dn[g]),
            .match_exp (mx[g]),
            .match_cnt (mcw),
            .cnt_clr   (clr[g])
        );
        assign mc[g] = 8'(mcw);
    end

    function automatic int gap_of(input int g);
        return (g == 1) ? 0 : 2;
    endfunction

    function automatic void chk(input string name, input int g,
                                input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, g, act, exp);
        end
    endfunction

    function automatic void flag(input string name, input int g);
        vectors++;
        miscompares++;
        $display("FAIL %s[%0d]: bound expired or unexpected event", name, g);
    endfunction

    task automatic send(input int g, input logic [7:0] data, input logic [3:0] len,
                        input logic [7:0] bits, input int n, input logic [7:0] mask);
        int   t = 0;
        ent_t e;
        while (lr[g] !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (lr[g] !== 1'b1) begin
            flag("ready_timeout", g);
            return;
        end
        if (n == 0) begin
            e.b = 1'b0; e.d = 1'b1; e.z = 1'b1; e.m = 1'b0;
            q[g].push_back(e);
        end else begin
            for (int i = 0; i < n; i++) begin
                e.b = bits[n-1-i];
                e.d = (i == n - 1);
                e.z = 1'b0;
                e.m = mask[n-1-i];
                q[g].push_back(e);
            end
        end
        ld[g] = data;
        ll[g] = len;
        lv[g] = 1'b1;
        @(posedge clk); #1;
        lv[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        int t = 0;
        while ((q[g].size() != 0 || lr[g] !== 1'b1) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) flag("drain_timeout", g);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog[0]: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        lv    = '0;
        clr   = '0;
        ld    = '0;
        ll    = '0;
        for (int g = 0; g < 3; g++) begin
            pend_m[g] = 1'b0;
            armed[g]  = 1'b0;
            since[g]  = 0;
        end

        fork
            begin : mon
                ent_t e;
                forever begin
                    @(negedge clk);
                    for (int g = 0; g < 3; g++) begin
                        if (rst_n !== 1'b1) begin
                            pend_m[g] = 1'b0;
                            armed[g]  = 1'b0;
                        end else begin
                            chk("match_exp", g, mx[g], pend_m[g]);
                            pend_m[g] = 1'b0;
                            if (!ov[g]) chk("idle_out", g, o[g], 0);
                            if (ov[g] || dn[g]) begin
                                if (q[g].size() == 0) begin
                                    flag("unexpected_output", g);
                                end else begin
                                    e = q[g].pop_front();
                                    chk("kind", g, {ov[g], dn[g]}, e.z ? 2'b01 : {1'b1, e.d});
                                    if (!e.z) chk("bit", g, o[g], e.b);
                                    pend_m[g] = e.m;
                                end
                            end
                            if (armed[g]) begin
                                since[g]++;
                                if (lr[g]) begin
                                    chk("gap_len", g, since[g], gap_of(g) + 1);
                                    armed[g] = 1'b0;
                                end else if (since[g] > 20) begin
                                    flag("gap_timeout", g);
                                    armed[g] = 1'b0;
                                end
                            end
                            if (ov[g] && dn[g]) begin
                                armed[g] = 1'b1;
                                since[g] = 0;
                            end
                        end
                    end
                end
            end
        join_none

        // Asynchronous reset pulse in the middle of the first cycle
        #2 rst_n = 1'b0;
        #0.5;
        for (int g = 0; g < 3; g++) begin
            chk("rst_out", g, o[g], 0);
            chk("rst_valid", g, ov[g], 0);
            chk("rst_done", g, dn[g], 0);
            chk("rst_ready", g, lr[g], 0);
            chk("rst_mexp", g, mx[g], 0);
            chk("rst_cnt", g, mc[g], 0);
        end
        #0.5 rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) chk("ready_after_rst", g, lr[g], 1);
        @(posedge clk); #1;

        // 101101: one match after the fourth bit
        send(0, 8'b00101101, 4'd6, 8'b00101101, 6, 8'b00000100);
        drain(0);
        chk("cnt_frame6", 0, mc[0], 1);
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        chk("cnt_clr_idle", 0, mc[0], 0);

        // 1011011: overlapping matches after bits 4 and 7
        send(0, 8'b01011011, 4'd7, 8'b01011011, 7, 8'b00001001);
        drain(0);
        chk("cnt_overlap", 0, mc[0], 2);

        // Gap zeros break cross-frame patterns
        send(0, 8'b00000101, 4'd3, 8'b00000101, 3, 8'b0);
        send(0, 8'b00000001, 4'd1, 8'b00000001, 1, 8'b0);
        drain(0);
        send(0, 8'b00001101, 4'd4, 8'b00001101, 4, 8'b0);
        send(0, 8'b00000011, 4'd2, 8'b00000011, 2, 8'b0);
        drain(0);
        chk("cnt_cross_gap2", 0, mc[0], 2);

        // GAP=0 instance: a single idle zero separates 101 and 1
        send(1, 8'b00000101, 4'd3, 8'b00000101, 3, 8'b0);
        send(1, 8'b00000001, 4'd1, 8'b00000001, 1, 8'b0);
        drain(1);
        chk("cnt_gap0", 1, mc[1], 0);

        // Reset during the third bit of an 8-bit frame
        send(0, 8'b10111000, 4'd8, 8'b10111000, 8, 8'b00010000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bit3_pre_rst", 0, o[0], 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out", 0, o[0], 0);
        chk("abort_valid", 0, ov[0], 0);
        chk("abort_done", 0, dn[0], 0);
        chk("abort_cnt", 0, mc[0], 0);
        q[0].delete();
        pend_m[0] = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 8'b00001011, 4'd4, 8'b00001011, 4, 8'b00000001);
        drain(0);
        chk("cnt_after_abort", 0, mc[0], 1);

        // len=9 clamps to all 8 bits: 11011001 matches once after bit 5
        send(0, 8'b11011001, 4'd9, 8'b11011001, 8, 8'b00001000);
        drain(0);
        chk("cnt_clamp", 0, mc[0], 2);

        // len=0: done pulse only
        send(0, 8'hFF, 4'd0, 8'b0, 0, 8'b0);
        drain(0);
        chk("len0_consumed", 0, q[0].size(), 0);
        chk("cnt_len0", 0, mc[0], 2);

        // CNT_W=2 saturation, then clear coinciding with a match
        for (int k = 0; k < 4; k++) send(2, 8'b00001011, 4'd4, 8'b00001011, 4, 8'b00000001);
        drain(2);
        chk("cnt_sat", 2, mc[2], 3);
        send(2, 8'b00001011, 4'd4, 8'b00001011, 4, 8'b00000001);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("mexp_at_clr", 2, mx[2], 1);
        clr[2] = 1'b1;
        @(posedge clk); #1;
        clr[2] = 1'b0;
        chk("cnt_clr_prio", 2, mc[2], 0);
        drain(2);
        chk("cnt_after_clr", 2, mc[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
